// File: rtl/led_count_bank.sv
// Bank of CHANNELS independent up/down/bounce/hold counters with per-channel
// enable, a single-port parallel load, per-channel wrap pulses and a registered LED slice.
module led_count_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int LED_W    = 8,
  parameter int LED_LSB  = 16,
  parameter int SEL_W    = 2
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] enable,
  input  logic [1:0]          mode,
  input  logic                load,
  input  logic [SEL_W-1:0]    load_ch,
  input  logic [WIDTH-1:0]    value,
  input  logic [SEL_W-1:0]    led_sel,
  output logic [LED_W-1:0]    led,
  output logic [CHANNELS-1:0] wrap
);

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

  if (LED_LSB + LED_W > WIDTH) begin : g_bad_led_slice
    $error("led_count_bank: LED_LSB+LED_W exceeds WIDTH");
  end
  if (CHANNELS < 1 || (CHANNELS > 1 && SEL_W < $clog2(CHANNELS))) begin : g_bad_sel_width
    $error("led_count_bank: CHANNELS < 1 or SEL_W too narrow");
  end

  logic [WIDTH-1:0]    cnt_r      [CHANNELS];
  logic [CHANNELS-1:0] dir_r;
  logic [LED_W-1:0]    led_r;
  logic [CHANNELS-1:0] wrap_r;

  logic [WIDTH-1:0]    cnt_nxt_s  [CHANNELS];
  logic [CHANNELS-1:0] dir_nxt_s;
  logic [CHANNELS-1:0] wrap_nxt_s;
  logic [LED_W-1:0]    led_nxt_s;

  // Per-channel next state: load beats step, hold when disabled or in hold mode.
  always_comb begin
    dir_nxt_s  = dir_r;
    wrap_nxt_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (load && (load_ch == SEL_W'(i))) begin
        cnt_nxt_s[i] = value;
        dir_nxt_s[i] = 1'b0;
      end else if (!enable[i] || (mode == MODE_HOLD)) begin
        cnt_nxt_s[i] = cnt_r[i];
      end else begin
        case (mode)
          MODE_UP: begin
            cnt_nxt_s[i]  = cnt_r[i] + CNT_ONE;
            wrap_nxt_s[i] = (cnt_r[i] == CNT_MAX);
          end
          MODE_DOWN: begin
            cnt_nxt_s[i]  = cnt_r[i] - CNT_ONE;
            wrap_nxt_s[i] = (cnt_r[i] == CNT_ZERO);
          end
          MODE_BOUNCE: begin
            // Turnaround reflects off the end value instead of repeating it.
            if (!dir_r[i] && (cnt_r[i] == CNT_MAX)) begin
              dir_nxt_s[i]  = 1'b1;
              cnt_nxt_s[i]  = CNT_MAX - CNT_ONE;
              wrap_nxt_s[i] = 1'b1;
            end else if (dir_r[i] && (cnt_r[i] == CNT_ZERO)) begin
              dir_nxt_s[i]  = 1'b0;
              cnt_nxt_s[i]  = CNT_ONE;
              wrap_nxt_s[i] = 1'b1;
            end else if (dir_r[i]) begin
              cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
              cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
          end
          default: begin
            cnt_nxt_s[i] = cnt_r[i];
          end
        endcase
      end
    end
  end

  // LED slice of the selected channel; out-of-range selects show zero.
  always_comb begin
    led_nxt_s = {LED_W{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (led_sel == SEL_W'(i)) begin
        led_nxt_s = cnt_r[i][LED_LSB +: LED_W];
      end else begin
        led_nxt_s = led_nxt_s;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      dir_r  <= {CHANNELS{1'b0}};
      wrap_r <= {CHANNELS{1'b0}};
      led_r  <= {LED_W{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      dir_r  <= dir_nxt_s;
      wrap_r <= wrap_nxt_s;
      led_r  <= led_nxt_s;
    end
  end

  assign led  = led_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_led_count_bank.sv
// Randomised and directed bench for led_count_bank (WIDTH=8, CHANNELS=4,
// LED_W=4, LED_LSB=4, SEL_W=3) against an arithmetic reference model.
module tb_led_count_bank;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] enable;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_ch;
  logic [7:0] value;
  logic [2:0] led_sel;
  logic [3:0] led;
  logic [3:0] wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: plain integers, counts kept in 0..255.
  int m_cnt [4];
  int m_dir [4];
  int m_led;
  int m_wrap [4];

  led_count_bank #(.WIDTH(8), .CHANNELS(4), .LED_W(4), .LED_LSB(4), .SEL_W(3)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .mode(mode), .load(load),
    .load_ch(load_ch), .value(value), .led_sel(led_sel), .led(led), .wrap(wrap)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int nxt;
    if (RST) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_dir[i] = 0; m_wrap[i] = 0;
      end
      m_led = 0;
    end else begin
      m_led = (int'(led_sel) < 4) ? (m_cnt[led_sel] / 16) % 16 : 0;
      for (int i = 0; i < 4; i++) begin
        m_wrap[i] = 0;
        if (load && int'(load_ch) == i) begin
          m_cnt[i] = int'(value); m_dir[i] = 0;
        end else if (enable[i] && mode != 2'd3) begin
          if (mode == 2'd0) begin
            m_wrap[i] = (m_cnt[i] == 255);
            m_cnt[i] = (m_cnt[i] + 1) % 256;
          end else if (mode == 2'd1) begin
            m_wrap[i] = (m_cnt[i] == 0);
            m_cnt[i] = (m_cnt[i] + 255) % 256;
          end else begin
            nxt = m_dir[i] ? m_cnt[i] - 1 : m_cnt[i] + 1;
            if (nxt > 255) begin
              m_cnt[i] = 254; m_dir[i] = 1; m_wrap[i] = 1;
            end else if (nxt < 0) begin
              m_cnt[i] = 1; m_dir[i] = 0; m_wrap[i] = 1;
            end else begin
              m_cnt[i] = nxt;
            end
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_val("led", led, m_led);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("cnt%0d", i), dut.cnt_r[i], m_cnt[i]);
      check_val($sformatf("wrap%0d", i), wrap[i], m_wrap[i]);
    end
  endtask

  task automatic idle_inputs();
    load = 1'b0; enable = 4'h0; mode = 2'd0; load_ch = 3'd0; value = 8'h00;
  endtask

  int   budget;
  logic [7:0] exp_up [4];
  logic       exp_uw [4];

  initial begin
    exp_up = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    exp_uw = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_dir[i] = 0; m_wrap[i] = 0;
    end
    m_led = 0;

    // Reset overrides load and enable
    RST = 1'b1; load = 1'b1; enable = 4'hF; value = 8'hFF; mode = 2'd0;
    load_ch = 3'd0; led_sel = 3'd0;
    step(); step();
    check_val("rst_led", led, 32'd0);
    check_val("rst_wrap", wrap, 32'd0);
    RST = 1'b0; idle_inputs();
    step(); step();
    check_val("idle_cnt0", dut.cnt_r[0], 32'd0);

    // Up wrap on channel 1
    load = 1'b1; load_ch = 3'd1; value = 8'hFD; led_sel = 3'd1;
    step();
    load = 1'b0; enable = 4'b0010; mode = 2'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("up_cnt1", dut.cnt_r[1], 32'(exp_up[k]));
      check_val("up_wrap1", wrap[1], 32'(exp_uw[k]));
    end
    step();
    check_val("up_led_lag", led, 32'h0);

    // Bounce on channel 2: top turnaround then run down to the bottom one
    idle_inputs(); led_sel = 3'd2;
    load = 1'b1; load_ch = 3'd2; value = 8'hFE;
    step();
    load = 1'b0; mode = 2'd2; enable = 4'b0100;
    step();
    check_val("bnc_top_cnt", dut.cnt_r[2], 32'hFF);
    step();
    check_val("bnc_top_cnt2", dut.cnt_r[2], 32'hFE);
    check_val("bnc_top_wrap", wrap[2], 32'd1);
    step();
    check_val("bnc_top_wrap_once", wrap[2], 32'd0);
    budget = 400;
    while (m_cnt[2] != 0 && budget > 0) begin
      step(); budget--;
    end
    check_val("bnc_reach_zero", dut.cnt_r[2], 32'h00);
    step();
    check_val("bnc_bot_cnt", dut.cnt_r[2], 32'h01);
    check_val("bnc_bot_wrap", wrap[2], 32'd1);
    step();
    check_val("bnc_bot_cnt2", dut.cnt_r[2], 32'h02);

    // Load beats step on channel 0; channel 3 still steps
    idle_inputs();
    load = 1'b1; load_ch = 3'd0; value = 8'h10;
    step();
    load = 1'b1; load_ch = 3'd0; value = 8'h80; mode = 2'd0; enable = 4'b1001;
    step();
    check_val("coll_cnt0", dut.cnt_r[0], 32'h80);
    check_val("coll_wrap0", wrap[0], 32'd0);

    // Reset while channel 2 bounces downward
    idle_inputs();
    load = 1'b1; load_ch = 3'd2; value = 8'hFF;
    step();
    load = 1'b0; mode = 2'd2; enable = 4'b0100;
    budget = 400;
    while (m_cnt[2] != 8'h40 && budget > 0) begin
      step(); budget--;
    end
    check_val("mid_at_40", dut.cnt_r[2], 32'h40);
    RST = 1'b1;
    step();
    check_val("mid_rst_dir", dut.dir_r[2], 32'd0);
    RST = 1'b0;
    step();
    check_val("mid_post1", dut.cnt_r[2], 32'h01);
    step();
    check_val("mid_post2", dut.cnt_r[2], 32'h02);

    // Hold mode, out-of-range led select and load channel
    mode = 2'd3; enable = 4'hF;
    step(); step();
    check_val("hold_cnt2", dut.cnt_r[2], 32'h02);
    led_sel = 3'd5;
    step();
    check_val("led_oob", led, 32'd0);
    load = 1'b1; load_ch = 3'd6; value = 8'hAA;
    step();
    check_val("load_oob_cnt2", dut.cnt_r[2], 32'h02);

    // Randomised traffic, loads biased toward the wrap boundaries
    for (int k = 0; k < 600; k++) begin
      RST     = ($urandom_range(0, 79) == 0);
      mode    = 2'($urandom_range(0, 3));
      enable  = 4'($urandom);
      load    = ($urandom_range(0, 4) == 0);
      load_ch = 3'($urandom_range(0, 7));
      led_sel = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: value = 8'h00;
        1: value = 8'h01;
        2: value = 8'hFE;
        3: value = 8'hFF;
        default: value = 8'($urandom);
      endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
